// File: rtl/seg7_bcd_display.sv
// N-digit BCD seven-segment display engine with a BCD up/down counter,
// per-digit blinking, leading-zero blanking and decimal points.
module seg7_bcd_display #(
    parameter int N_DIGITS       = 4,
    parameter int CLK_HZ         = 50000000,
    parameter int BLINK_HZ       = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic                    wr_en,
    input  logic [4*N_DIGITS-1:0]   wr_data,
    input  logic [1:0]              mode,
    input  logic                    tick,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blink_mask,
    input  logic                    lz_blank,
    output logic [8*N_DIGITS-1:0]   seg_out,
    output logic [4*N_DIGITS-1:0]   digits_out,
    output logic                    wrap
);

    localparam int HP_RAW = CLK_HZ / (2 * BLINK_HZ);
    localparam int HP     = (HP_RAW < 1) ? 1 : HP_RAW;
    localparam int BW     = (HP > 1) ? $clog2(HP) : 1;
    localparam logic [8*N_DIGITS-1:0] SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;

    logic [4*N_DIGITS-1:0] value_q, value_d;
    logic                  wrap_q, wrap_d;
    logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [8*N_DIGITS-1:0] seg_q, seg_d;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h3F;
            4'd1:    enc = 7'h06;
            4'd2:    enc = 7'h5B;
            4'd3:    enc = 7'h4F;
            4'd4:    enc = 7'h66;
            4'd5:    enc = 7'h6D;
            4'd6:    enc = 7'h7D;
            4'd7:    enc = 7'h07;
            4'd8:    enc = 7'h7F;
            4'd9:    enc = 7'h6F;
            default: enc = 7'h00;
        endcase
    endfunction

    // Ripple carry/borrow resolves across every digit in one cycle.
    always_comb begin
        logic       carry;
        logic [3:0] nib;
        value_d = value_q;
        wrap_d  = 1'b0;
        carry   = 1'b1;
        nib     = 4'd0;
        if (wr_en) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                nib = wr_data[4*i +: 4];
                value_d[4*i +: 4] = (nib > 4'd9) ? 4'd9 : nib;
            end
        end else if (tick && mode == 2'b01) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                nib = value_q[4*i +: 4];
                if (carry) begin
                    if (nib == 4'd9) begin
                        value_d[4*i +: 4] = 4'd0;
                    end else begin
                        value_d[4*i +: 4] = nib + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            wrap_d = carry;
        end else if (tick && mode == 2'b10) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                nib = value_q[4*i +: 4];
                if (carry) begin
                    if (nib == 4'd0) begin
                        value_d[4*i +: 4] = 4'd9;
                    end else begin
                        value_d[4*i +: 4] = nib - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            wrap_d = carry;
        end
    end

    always_comb begin
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BW'(HP - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Scan from the top digit so upper_zero covers digits i..N_DIGITS-1.
    always_comb begin
        logic       upper_zero;
        logic [7:0] field;
        logic [3:0] nib;
        seg_d      = SEG_OFF;
        upper_zero = 1'b1;
        field      = 8'h00;
        nib        = 4'd0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            nib        = value_q[4*i +: 4];
            upper_zero = upper_zero & (nib == 4'd0);
            field      = 8'h00;
            if (!(blink_phase_q && blink_mask[i])) begin
                field[7] = dp_in[i];
                if (!(lz_blank && i > 0 && upper_zero))
                    field[6:0] = enc(nib);
            end
            seg_d[8*i +: 8] = SEG_ACTIVE_LOW ? ~field : field;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            value_q       <= '0;
            wrap_q        <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_OFF;
        end else begin
            value_q       <= value_d;
            wrap_q        <= wrap_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
        end
    end

    assign seg_out    = seg_q;
    assign digits_out = value_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Scoreboard bench: the driver pushes the expected post-edge outputs of a
// decimal-arithmetic reference model; a monitor pops and compares each cycle.
module tb_seg7_bcd_display;

    localparam int N      = 4;
    localparam int CLK_HZ = 8;
    localparam int BLK_HZ = 1;
    localparam int HP     = CLK_HZ / (2 * BLK_HZ);
    localparam int MODV   = 10000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [4*N-1:0]    wr_data = '0;
    logic [1:0]        mode = 2'b00;
    logic              tick = 1'b0;
    logic [N-1:0]      dp_in = '0;
    logic [N-1:0]      blink_mask = '0;
    logic              lz_blank = 1'b0;
    logic [8*N-1:0]    seg_out;
    logic [4*N-1:0]    digits_out;
    logic              wrap;

    seg7_bcd_display #(
        .N_DIGITS(N), .CLK_HZ(CLK_HZ), .BLINK_HZ(BLK_HZ), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_clk(clk), .reset_reset(rst), .wr_en(wr_en), .wr_data(wr_data),
        .mode(mode), .tick(tick), .dp_in(dp_in), .blink_mask(blink_mask),
        .lz_blank(lz_blank), .seg_out(seg_out), .digits_out(digits_out),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*N-1:0] dig;
        logic [8*N-1:0] seg;
        logic           wrp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mval   = 0;
    int   mcyc   = 0;
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic int pow10(input int e);
        int r = 1;
        for (int k = 0; k < e; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [4*N-1:0] to_bcd(input int v);
        logic [4*N-1:0] r = '0;
        for (int k = 0; k < N; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    function automatic logic [8*N-1:0] display(input int v, input int phase,
            input logic [N-1:0] dp, input logic [N-1:0] bm, input logic lz);
        logic [8*N-1:0] r = '0;
        logic [7:0]     f;
        for (int k = 0; k < N; k++) begin
            f = 8'h00;
            if (!(phase == 1 && bm[k])) begin
                f[7] = dp[k];
                if (!(lz && k > 0 && v < pow10(k)))
                    f[6:0] = seg_tab[(v / pow10(k)) % 10];
            end
            r[8*k +: 8] = ~f;
        end
        return r;
    endfunction

    task automatic model_step();
        exp_t e;
        int   wv;
        if (rst) begin
            mval  = 0;
            mcyc  = 0;
            e.seg = '1;
            e.wrp = 1'b0;
        end else begin
            e.seg = display(mval, (mcyc / HP) % 2, dp_in, blink_mask, lz_blank);
            e.wrp = 1'b0;
            mcyc++;
            if (wr_en) begin
                wv = 0;
                for (int k = 0; k < N; k++)
                    wv += ((wr_data[4*k +: 4] > 9) ? 9 : int'(wr_data[4*k +: 4])) * pow10(k);
                mval = wv;
            end else if (tick && mode == 2'b01) begin
                e.wrp = (mval == MODV - 1);
                mval  = (mval + 1) % MODV;
            end else if (tick && mode == 2'b10) begin
                e.wrp = (mval == 0);
                mval  = (mval + MODV - 1) % MODV;
            end
        end
        e.dig = to_bcd(mval);
        sb.push_back(e);
    endtask

    task automatic drive(input logic r, input logic w, input logic [4*N-1:0] wd,
                         input logic [1:0] md, input logic tk);
        rst = r; wr_en = w; wr_data = wd; mode = md; tick = tk;
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, '0, mode, 1'b0);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (digits_out !== e.dig) begin
                errors++;
                $display("FAIL digits_out: got %h expected %h at %0t", digits_out, e.dig, $time);
            end
            checks++;
            if (seg_out !== e.seg) begin
                errors++;
                $display("FAIL seg_out: got %h expected %h at %0t", seg_out, e.seg, $time);
            end
            checks++;
            if (wrap !== e.wrp) begin
                errors++;
                $display("FAIL wrap: got %b expected %b at %0t", wrap, e.wrp, $time);
            end
        end
    end

    initial begin
        drive(1'b1, 1'b0, '0, 2'b00, 1'b0);
        drive(1'b1, 1'b0, '0, 2'b00, 1'b0);
        idle(2);
        drive(1'b0, 1'b1, 16'h1234, 2'b00, 1'b0); idle(2);
        drive(1'b0, 1'b1, 16'h12AF, 2'b00, 1'b0); idle(2);
        drive(1'b0, 1'b1, 16'h0999, 2'b01, 1'b0);
        drive(1'b0, 1'b0, '0, 2'b01, 1'b1); idle(2);
        drive(1'b0, 1'b1, 16'h9999, 2'b01, 1'b0);
        drive(1'b0, 1'b0, '0, 2'b01, 1'b1); idle(2);
        drive(1'b0, 1'b1, 16'h0005, 2'b01, 1'b1); idle(2);
        drive(1'b0, 1'b1, 16'h0000, 2'b10, 1'b0);
        drive(1'b0, 1'b0, '0, 2'b10, 1'b1);
        drive(1'b0, 1'b0, '0, 2'b10, 1'b1); idle(2);
        drive(1'b0, 1'b0, '0, 2'b11, 1'b1);
        drive(1'b0, 1'b0, '0, 2'b00, 1'b1);
        lz_blank = 1'b1; dp_in = 4'b0100;
        drive(1'b0, 1'b1, 16'h0040, 2'b00, 1'b0); idle(2);
        drive(1'b0, 1'b1, 16'h0000, 2'b00, 1'b0); idle(2);
        lz_blank = 1'b0; dp_in = 4'b0000; blink_mask = 4'b0001;
        drive(1'b0, 1'b1, 16'h0008, 2'b00, 1'b0); idle(13);
        drive(1'b1, 1'b0, '0, 2'b00, 1'b0);
        drive(1'b0, 1'b1, 16'h0008, 2'b00, 1'b0); idle(10);
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                dp_in      = 4'($urandom);
                blink_mask = 4'($urandom);
                lz_blank   = 1'($urandom);
            end
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
                  16'($urandom), 2'($urandom), 1'($urandom));
        end
        idle(2);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
